// File: rtl/dma_controller.sv
// dma_controller: single-channel 8-bit DMA engine with a 16-bit address bus.
// Optional DMAC_AUTOINIT_EN reloads count/src/dst from base copies at DONE.
module dma_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic        HLDA,
  input  logic        BG,
  input  logic        RDY,
  input  logic        REGW,
  input  logic [1:0]  REGSEL,
  input  logic [15:0] Setup,
  input  logic [7:0]  Data_in,
  output logic        HLD,
  output logic        DACK,
  output logic        MEMR,
  output logic        MEMW,
  output logic        IOR,
  output logic        IOW,
  output logic        EOP,
  output logic [15:0] Addrbus,
  output logic [7:0]  Data_out
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_LATCH, S_WRITE, S_DONE
  } state_t;

  state_t      r_state, w_nstate;
  logic [7:0]  r_mode, w_nmode;
  logic [15:0] r_cnt, r_src, r_dst;
  logic [15:0] w_ncnt, w_nsrc, w_ndst;
  logic [7:0]  r_temp, w_ntemp;
  logic        w_grant, w_flyby, w_steal;
  logic        w_io_in, w_io_out, w_reqhld;
  logic        w_hld, w_dack, w_memr, w_memw;
  logic        w_ior, w_iow, w_eop;
  logic [15:0] w_addr;
  logic [7:0]  w_dout;
  logic        w_unused;

`ifdef DMAC_AUTOINIT_EN
  logic [15:0] r_bcnt, r_bsrc, r_bdst;
`endif

  assign w_grant  = r_mode[7] ? BG : HLDA;
  assign w_flyby  = r_mode[5];
  assign w_steal  = (r_mode[7:6] == 2'b01);
  assign w_io_in  = (r_mode[2:1] == 2'b01);
  assign w_io_out = (r_mode[2:1] == 2'b10);
  assign w_unused = &{1'b0, r_mode[4:3]};

  always_comb begin
    w_nstate = r_state;
    w_nmode  = r_mode;
    w_ncnt   = r_cnt;
    w_nsrc   = r_src;
    w_ndst   = r_dst;
    w_ntemp  = r_temp;
    w_reqhld = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (REGW) begin
          unique case (REGSEL)
            2'b00: w_nmode = Setup[7:0];
            2'b01: w_ncnt  = Setup;
            2'b10: w_nsrc  = Setup;
            default: w_ndst = Setup;
          endcase
        end else if (r_mode[0] && DREQ) begin
          w_nstate = (r_cnt == 16'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // a dropped HLD (cycle steal) is re-raised before grant counts
        if (HLD && w_grant) w_nstate = S_READ;
      end
      S_READ: begin
        if (RDY) begin
          w_ntemp  = Data_in;
          w_nstate = w_flyby ? S_WRITE : S_LATCH;
        end
      end
      S_LATCH: w_nstate = S_WRITE;
      S_WRITE: begin
        if (RDY) begin
          w_nsrc = r_src + 16'd1;
          w_ndst = r_dst + 16'd1;
          w_ncnt = r_cnt - 16'd1;
          if (w_ncnt == 16'd0) begin
            w_nstate = S_DONE;
          end else if (!DREQ) begin
            w_nstate = S_IDLE;
          end else if (!w_grant) begin
            w_nstate = S_REQ;
          end else if (w_steal) begin
            w_nstate = S_REQ;
            w_reqhld = 1'b0;
          end else begin
            w_nstate = S_READ;
          end
        end
      end
      S_DONE: begin
        w_nstate = S_IDLE;
`ifdef DMAC_AUTOINIT_EN
        w_ncnt = r_bcnt;
        w_nsrc = r_bsrc;
        w_ndst = r_bdst;
`else
        w_nmode[0] = 1'b0;
`endif
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    w_hld  = 1'b0;
    w_dack = 1'b0;
    w_memr = 1'b0;
    w_memw = 1'b0;
    w_ior  = 1'b0;
    w_iow  = 1'b0;
    w_eop  = 1'b0;
    w_addr = 16'd0;
    w_dout = Data_out;
    unique case (w_nstate)
      S_REQ: w_hld = w_reqhld;
      S_READ, S_LATCH: begin
        w_hld  = 1'b1;
        w_dack = 1'b1;
        w_addr = w_io_in ? w_ndst : w_nsrc;
        if (w_nstate == S_READ) begin
          w_ior  = w_io_in;
          w_memr = !w_io_in;
        end
      end
      S_WRITE: begin
        w_hld  = 1'b1;
        w_dack = 1'b1;
        w_iow  = w_io_out;
        w_memw = !w_io_out;
        w_addr = w_io_out ? w_nsrc : w_ndst;
        w_dout = w_ntemp;
      end
      S_DONE: w_eop = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_mode   <= 8'd0;
      r_cnt    <= 16'd0;
      r_src    <= 16'd0;
      r_dst    <= 16'd0;
      r_temp   <= 8'd0;
      HLD      <= 1'b0;
      DACK     <= 1'b0;
      MEMR     <= 1'b0;
      MEMW     <= 1'b0;
      IOR      <= 1'b0;
      IOW      <= 1'b0;
      EOP      <= 1'b0;
      Addrbus  <= 16'd0;
      Data_out <= 8'd0;
    end else begin
      r_state  <= w_nstate;
      r_mode   <= w_nmode;
      r_cnt    <= w_ncnt;
      r_src    <= w_nsrc;
      r_dst    <= w_ndst;
      r_temp   <= w_ntemp;
      HLD      <= w_hld;
      DACK     <= w_dack;
      MEMR     <= w_memr;
      MEMW     <= w_memw;
      IOR      <= w_ior;
      IOW      <= w_iow;
      EOP      <= w_eop;
      Addrbus  <= w_addr;
      Data_out <= w_dout;
    end
  end

`ifdef DMAC_AUTOINIT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bcnt <= 16'd0;
      r_bsrc <= 16'd0;
      r_bdst <= 16'd0;
    end else if (r_state == S_IDLE && REGW) begin
      unique case (REGSEL)
        2'b01: r_bcnt <= Setup;
        2'b10: r_bsrc <= Setup;
        2'b11: r_bdst <= Setup;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed cycle-exact checks of the dma_controller.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_dma_controller;
  logic        CLK = 1'b0;
  logic        RST, DREQ, HLDA, BG, RDY, REGW;
  logic [1:0]  REGSEL;
  logic [15:0] Setup;
  logic [7:0]  Data_in;
  logic        HLD, DACK, MEMR, MEMW, IOR, IOW, EOP;
  logic [15:0] Addrbus;
  logic [7:0]  Data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  wire [6:0] w_st = {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP};

  localparam logic [6:0] ST_IDLE = 7'b0000000;
  localparam logic [6:0] ST_REQ  = 7'b1000000;
  localparam logic [6:0] ST_MR   = 7'b1110000;
  localparam logic [6:0] ST_MW   = 7'b1101000;
  localparam logic [6:0] ST_IR   = 7'b1100100;
  localparam logic [6:0] ST_IW   = 7'b1100010;
  localparam logic [6:0] ST_LAT  = 7'b1100000;
  localparam logic [6:0] ST_EOP  = 7'b0000001;

  always #5 CLK = ~CLK;

  dma_controller dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .HLDA(HLDA), .BG(BG),
    .RDY(RDY), .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup),
    .Data_in(Data_in), .HLD(HLD), .DACK(DACK), .MEMR(MEMR),
    .MEMW(MEMW), .IOR(IOR), .IOW(IOW), .EOP(EOP),
    .Addrbus(Addrbus), .Data_out(Data_out)
  );

  task automatic prog(input logic [7:0] m, input logic [15:0] c,
                      input logic [15:0] s, input logic [15:0] d);
    @(negedge CLK); REGW = 1'b1; REGSEL = 2'b01; Setup = c;
    @(negedge CLK); REGSEL = 2'b10; Setup = s;
    @(negedge CLK); REGSEL = 2'b11; Setup = d;
    @(negedge CLK); REGSEL = 2'b00; Setup = {8'h00, m};
    @(negedge CLK); REGW = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; DREQ = 0; HLDA = 0; BG = 0; RDY = 1; REGW = 0;
    REGSEL = 0; Setup = 0; Data_in = 0;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_IDLE || Addrbus !== 16'h0 || Data_out !== 8'h0) begin
      n_fail++;
      $display("FAIL reset st=%b addr=%h dout=%h exp 0", w_st, Addrbus, Data_out);
    end
    RST = 1'b0;
  endtask

  task automatic test_flyby_m2m();
    logic [7:0] d [3];
    d = '{8'hA1, 8'h3C, 8'hF0};
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE1, 16'd3, 16'h0050, 16'h0001);
    DREQ = 1;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_REQ) begin
      n_fail++;
      $display("FAIL t1_req st=%b exp %b", w_st, ST_REQ);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MR || Addrbus !== 16'(16'h0050 + i)) begin
        n_fail++;
        $display("FAIL t1_read%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_MR, 16'(16'h0050 + i));
      end
      Data_in = d[i];
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MW || Addrbus !== 16'(16'h0001 + i) || Data_out !== d[i]) begin
        n_fail++;
        $display("FAIL t1_write%0d st=%b addr=%h dout=%h exp %b %h %h", i, w_st,
                 Addrbus, Data_out, ST_MW, 16'(16'h0001 + i), d[i]);
      end
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP || Addrbus !== 16'h0) begin
      n_fail++;
      $display("FAIL t1_eop st=%b addr=%h exp %b 0000", w_st, Addrbus, ST_EOP);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_IDLE || Data_out !== d[2]) begin
        n_fail++;
        $display("FAIL t1_idle%0d st=%b dout=%h exp %b %h", i, w_st, Data_out,
                 ST_IDLE, d[2]);
      end
    end
    DREQ = 0;
  endtask

  task automatic test_bg_drop();
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE1, 16'd3, 16'h0050, 16'h0001);
    DREQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MR || Addrbus !== 16'h0050) begin
      n_fail++;
      $display("FAIL t2_read0 st=%b addr=%h exp %b 0050", w_st, Addrbus, ST_MR);
    end
    Data_in = 8'h11; BG = 0;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MW || Addrbus !== 16'h0001 || Data_out !== 8'h11) begin
      n_fail++;
      $display("FAIL t2_write0 st=%b addr=%h dout=%h exp %b 0001 11", w_st,
               Addrbus, Data_out, ST_MW);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_REQ || Addrbus !== 16'h0) begin
        n_fail++;
        $display("FAIL t2_wait%0d st=%b addr=%h exp %b 0000", i, w_st, Addrbus, ST_REQ);
      end
    end
    BG = 1;
    for (int i = 1; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MR || Addrbus !== 16'(16'h0050 + i)) begin
        n_fail++;
        $display("FAIL t2_read%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_MR, 16'(16'h0050 + i));
      end
      Data_in = 8'(8'h20 + i);
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MW || Addrbus !== 16'(16'h0001 + i)) begin
        n_fail++;
        $display("FAIL t2_write%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_MW, 16'(16'h0001 + i));
      end
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t2_eop st=%b exp %b", w_st, ST_EOP);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_IDLE) begin
        n_fail++;
        $display("FAIL t2_extra%0d st=%b exp %b", i, w_st, ST_IDLE);
      end
    end
    DREQ = 0;
  endtask

  task automatic test_fetch_io2mem();
    logic [7:0] d [2];
    d = '{8'h5A, 8'hC3};
    BG = 0; HLDA = 1; RDY = 1;
    prog(8'h03, 16'd2, 16'h2222, 16'h1000);
    DREQ = 1;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_REQ) begin
      n_fail++;
      $display("FAIL t3_req st=%b exp %b", w_st, ST_REQ);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_IR || Addrbus !== 16'(16'h1000 + i)) begin
        n_fail++;
        $display("FAIL t3_read%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_IR, 16'(16'h1000 + i));
      end
      Data_in = d[i];
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_LAT) begin
        n_fail++;
        $display("FAIL t3_latch%0d st=%b exp %b", i, w_st, ST_LAT);
      end
      Data_in = 8'hEE;
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MW || Addrbus !== 16'(16'h1000 + i) || Data_out !== d[i]) begin
        n_fail++;
        $display("FAIL t3_write%0d st=%b addr=%h dout=%h exp %b %h %h", i, w_st,
                 Addrbus, Data_out, ST_MW, 16'(16'h1000 + i), d[i]);
      end
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t3_eop st=%b exp %b", w_st, ST_EOP);
    end
    DREQ = 0; HLDA = 0;
    @(negedge CLK);
  endtask

  task automatic test_rdy_wait();
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE5, 16'd1, 16'h0300, 16'h0400);
    DREQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MR || Addrbus !== 16'h0300) begin
      n_fail++;
      $display("FAIL t4_read st=%b addr=%h exp %b 0300", w_st, Addrbus, ST_MR);
    end
    RDY = 0; Data_in = 8'h11;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MR || Addrbus !== 16'h0300) begin
        n_fail++;
        $display("FAIL t4_hold%0d st=%b addr=%h exp %b 0300", i, w_st, Addrbus, ST_MR);
      end
    end
    RDY = 1; Data_in = 8'h77;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_IW || Addrbus !== 16'h0300 || Data_out !== 8'h77) begin
      n_fail++;
      $display("FAIL t4_write st=%b addr=%h dout=%h exp %b 0300 77", w_st,
               Addrbus, Data_out, ST_IW);
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t4_eop st=%b exp %b", w_st, ST_EOP);
    end
    DREQ = 0;
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE3, 16'd2, 16'h0000, 16'hFFFF);
    DREQ = 1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_IR || Addrbus !== 16'(16'hFFFF + i)) begin
        n_fail++;
        $display("FAIL t5_read%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_IR, 16'(16'hFFFF + i));
      end
      Data_in = 8'(8'h90 + i);
      @(negedge CLK);
      n_cmp++;
      if (w_st !== ST_MW || Addrbus !== 16'(16'hFFFF + i)) begin
        n_fail++;
        $display("FAIL t5_write%0d st=%b addr=%h exp %b %h", i, w_st, Addrbus,
                 ST_MW, 16'(16'hFFFF + i));
      end
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t5_eop st=%b exp %b", w_st, ST_EOP);
    end
    DREQ = 0;
    @(negedge CLK);
  endtask

  task automatic test_zero_count();
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE1, 16'd0, 16'h0100, 16'h0200);
    DREQ = 1;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t6_eop st=%b exp %b", w_st, ST_EOP);
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL t6_idle st=%b exp %b", w_st, ST_IDLE);
    end
    DREQ = 0;
  endtask

  task automatic test_cycle_steal();
    BG = 0; HLDA = 1; RDY = 1;
    prog(8'h61, 16'd2, 16'h0010, 16'h0020);
    DREQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MR || Addrbus !== 16'h0010) begin
      n_fail++;
      $display("FAIL t7_read0 st=%b addr=%h exp %b 0010", w_st, Addrbus, ST_MR);
    end
    Data_in = 8'h33;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MW || Addrbus !== 16'h0020) begin
      n_fail++;
      $display("FAIL t7_write0 st=%b addr=%h exp %b 0020", w_st, Addrbus, ST_MW);
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL t7_hlddrop st=%b exp %b", w_st, ST_IDLE);
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_REQ) begin
      n_fail++;
      $display("FAIL t7_rereq st=%b exp %b", w_st, ST_REQ);
    end
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MR || Addrbus !== 16'h0011) begin
      n_fail++;
      $display("FAIL t7_read1 st=%b addr=%h exp %b 0011", w_st, Addrbus, ST_MR);
    end
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_EOP) begin
      n_fail++;
      $display("FAIL t7_eop st=%b exp %b", w_st, ST_EOP);
    end
    DREQ = 0; HLDA = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    BG = 1; HLDA = 0; RDY = 1;
    prog(8'hE1, 16'd3, 16'h0050, 16'h0001);
    DREQ = 1;
    @(negedge CLK);
    @(negedge CLK);
    Data_in = 8'h42;
    REGW = 1; REGSEL = 2'b10; Setup = 16'h9999;
    @(negedge CLK);
    REGW = 0;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_MR || Addrbus !== 16'h0051) begin
      n_fail++;
      $display("FAIL t8_regw_ignored st=%b addr=%h exp %b 0051", w_st, Addrbus, ST_MR);
    end
    #2 RST = 1;
    #1;
    n_cmp++;
    if (w_st !== ST_IDLE || Addrbus !== 16'h0 || Data_out !== 8'h0) begin
      n_fail++;
      $display("FAIL t8_async_rst st=%b addr=%h dout=%h exp 0", w_st, Addrbus, Data_out);
    end
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    n_cmp++;
    if (w_st !== ST_IDLE) begin
      n_fail++;
      $display("FAIL t8_no_eop st=%b exp %b", w_st, ST_IDLE);
    end
    DREQ = 0;
  endtask

  initial begin
    test_reset();
    test_flyby_m2m();
    test_bg_drop();
    test_fetch_io2mem();
    test_rdy_wait();
    test_wrap();
    test_zero_count();
    test_cycle_steal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_controller.md
# dma_controller

Single-channel 8-bit DMA controller with a 16-bit address bus, sitting between the CPU bus arbiter, system memory and one I/O device. The CPU programs four setup registers, then the block requests the bus and moves a counted block of bytes. It supports mem→mem, I/O→mem and mem→I/O directions, flyby or fetch-and-deposit data paths, and burst, cycle-steal or transparent bus modes. It signals completion with EOP.

## Interface
No parameters.
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- DREQ  in  1  device/software transfer request
- HLDA  in  1  hold acknowledge from CPU; grant in burst/cycle-steal modes
- BG  in  1  bus-free grant; grant in transparent mode
- RDY  in  1  memory/device ready; low inserts wait states
- REGW  in  1  register write strobe
- REGSEL  in  2  register select: 00 mode, 01 count, 10 source address, 11 destination address
- Setup  in  16  register write data
- Data_in  in  8  read data bus
- HLD  out  1  bus hold request
- DACK  out  1  DMA acknowledge; high during active transfer cycles
- MEMR, MEMW, IOR, IOW  out  1 each  active-high bus strobes
- EOP  out  1  end-of-process pulse
- Addrbus  out  16  address bus
- Data_out  out  8  write data bus

## Operation
- Register write: when REGW=1 at a rising CLK edge, Setup is loaded into the register selected by REGSEL. The mode register takes Setup[7:0]. Writes are accepted only in IDLE; otherwise they are ignored.
- Mode bits:
  - [0] enable
  - [2:1] direction: 00 mem→mem, 01 I/O→mem, 10 mem→I/O, 11 treated as 00
  - [4:3] reserved
  - [5] flyby=1, fetch-and-deposit=0
  - [7:6] bus mode: 00 burst, 01 cycle-steal, 1x transparent
- Count = number of bytes to transfer. A count of 0 transfers nothing; the block raises EOP immediately when started.
- Grant = BG in transparent mode, HLDA otherwise.
- States: IDLE, REQ, READ, LATCH, WRITE, DONE.
  - IDLE→REQ when enable=1 and DREQ=1.
  - REQ: HLD=1. On the first grant cycle, go to READ.
  - READ: DACK=1.
    - mem→mem: Addrbus=src, MEMR=1.
    - I/O→mem: IOR=1, Addrbus=dst.
    - mem→I/O: MEMR=1, Addrbus=src.
    - Data_in is captured into a temp register at the end of the cycle.
  - LATCH (fetch-and-deposit only): one cycle, all strobes low, DACK=1.
  - WRITE: DACK=1, Data_out=temp.
    - mem→mem: Addrbus=dst, MEMW=1.
    - I/O→mem: Addrbus=dst, MEMW=1.
    - mem→I/O: IOW=1, Addrbus=src.
    - At the end of the cycle: src+1, dst+1, count−1. Addresses wrap modulo 2^16.
  - After WRITE:
    - count reaches 0 → DONE.
    - Else if DREQ=0 → IDLE, with HLD dropped.
    - Else if grant=0 → REQ.
    - Else if cycle-steal → REQ, with HLD dropped for one cycle.
    - Otherwise → READ.
  - DONE: EOP=1 for one cycle, HLD=0, enable cleared, then IDLE.
- Losing grant in the middle of a byte does not abort it. The byte in progress completes through WRITE.
- Idle outputs: Addrbus=0, all strobes, DACK and HLD low. Data_out holds its last value.

## Timing
- Reset: all registers, temp, Data_out, Addrbus and all outputs go to 0; state goes to IDLE.
- HLD rises one cycle after DREQ and enable are both seen in IDLE.
- Per-byte latency after grant:
  - flyby: 2 cycles (READ, WRITE)
  - fetch-and-deposit: 3 cycles
- RDY=0 during READ or WRITE freezes the state. Strobes, Addrbus and counters hold until the rising edge where RDY=1.
- EOP is asserted in the cycle after the last WRITE and lasts exactly one cycle.
- RST asserted mid-transfer aborts immediately, with no EOP.

## Configuration
- DMAC_AUTOINIT_EN:
  - Defined: base copies of count, src and dst are saved on register write. At DONE, the working registers reload from the base copies and enable stays set. EOP still pulses.
  - Undefined: enable clears at DONE and registers keep their final values.

## Test plan
- Transparent flyby mem→mem (mode=0x00E1, count=3, src=0x0050, dst=0x0001), DREQ=RDY=BG=1:
  - Addrbus sequence 0x0050/0x0001, 0x0051/0x0002, 0x0052/0x0003, alternating MEMR/MEMW.
  - Data_out equals Data_in sampled in each READ.
  - EOP pulses once, then HLD=0.
- BG low for 40 ns mid-block in the same setup: the current byte completes, the block waits in REQ with HLD=1, and resumes at the next address when BG returns. Exactly 3 bytes are transferred in total.
- Fetch-and-deposit burst I/O→mem (mode=0x0003, count=2, dst=0x1000), HLDA=1: two 3-cycle IOR/MEMW transfers to 0x1000 and 0x1001, then EOP.
- RDY=0 for 2 cycles during READ: strobes and Addrbus are held, and the transfer finishes 2 cycles later than nominal.
- Wrap-around: dst=0xFFFF, count=2 → writes go to 0xFFFF, then 0x0000.
- RST pulsed mid-transfer: all outputs go to 0 immediately, with no EOP. REGW writes are ignored while HLD=1.
